// File: rtl/yacht_pkg.sv
// -----------------------------------------------------------------------------
// yacht_pkg
//   Shared definitions for the Yacht turn/round controller: game constants,
//   scoring-category indices, the turn FSM state encoding and a helper that
//   decides whether a category selection may be committed.
//   No ports (package).
// -----------------------------------------------------------------------------
package yacht_pkg;

  // Game shape
  localparam int NUM_CAT   = 12;  // scoring categories == rounds per game
  localparam int MAX_ROLLS = 3;   // rolls allowed per turn

  // Field widths of the category / round / roll counters
  localparam int CAT_W   = 4;
  localparam int ROUND_W = 4;
  localparam int ROLLS_W = 2;

  // Scoring category indices
  localparam logic [CAT_W-1:0] CAT_ACES   = 4'd0;
  localparam logic [CAT_W-1:0] CAT_TWOS   = 4'd1;
  localparam logic [CAT_W-1:0] CAT_THREES = 4'd2;
  localparam logic [CAT_W-1:0] CAT_FOURS  = 4'd3;
  localparam logic [CAT_W-1:0] CAT_FIVES  = 4'd4;
  localparam logic [CAT_W-1:0] CAT_SIXES  = 4'd5;
  localparam logic [CAT_W-1:0] CAT_CHOICE = 4'd6;
  localparam logic [CAT_W-1:0] CAT_4KIND  = 4'd7;
  localparam logic [CAT_W-1:0] CAT_FULLH  = 4'd8;
  localparam logic [CAT_W-1:0] CAT_SSTR   = 4'd9;
  localparam logic [CAT_W-1:0] CAT_LSTR   = 4'd10;
  localparam logic [CAT_W-1:0] CAT_YACHT  = 4'd11;

  // Turn FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,  // waiting for the first roll of a turn
    ROLLING   = 3'd1,  // roll_en burst in progress
    DECIDE    = 3'd2,  // player may re-roll or confirm a category
    COMMIT    = 3'd3,  // single-cycle category commit
    GAME_OVER = 3'd4   // all categories used; only reset leaves
  } turn_state_e;

  // A selection is committable when it names a real category that has not
  // been scored yet. Out-of-range indices are rejected before the mask is
  // looked at so the lookup never reads past the top bit.
  function automatic logic cat_is_free(input logic [CAT_W-1:0]   sel,
                                       input logic [NUM_CAT-1:0] used);
    logic ok;
    ok = 1'b0;
    if (sel < CAT_W'(NUM_CAT)) begin
      ok = ~used[sel];
    end
    return ok;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Brings a raw asynchronous push-button into the clock domain, debounces it
//   and emits a single-cycle pulse on each accepted press.
//
//   Ports
//     clk_i    in  1  system clock
//     reset_i  in  1  synchronous active-high reset (button treated as released)
//     btn_i    in  1  raw button level, asynchronous, active-high
//     press_o  out 1  one-cycle pulse on the rising edge of the debounced level
//
//   Latency from a clean button edge to press_o is 2 + DEBOUNCE_CYCLES cycles:
//   two synchronizer stages, then DEBOUNCE_CYCLES consecutive differing
//   samples before the debounced level flips (press_o is registered alongside
//   the level, so it adds no further cycle).
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // The counter tracks how many consecutive samples the synchronized input
  // has disagreed with the accepted level; any agreeing sample restarts it.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q;  // only the released->pressed flip is a press
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/yacht_turn_ctrl.sv
// -----------------------------------------------------------------------------
// yacht_turn_ctrl
//   Turn/round controller sitting in front of the dice manager. Debounces the
//   Roll and Confirm buttons, issues ROLL_CYCLES-long roll_en bursts, limits a
//   turn to MAX_ROLLS rolls (first roll of a turn always rolls every die),
//   validates and commits the chosen scoring category and counts the rounds
//   up to game over.
//
//   Ports
//     clk          in  1   system clock
//     reset        in  1   synchronous active-high reset
//     roll_btn     in  1   raw Roll button (async, active-high)
//     confirm_btn  in  1   raw Confirm button (async, active-high)
//     hold_sw      in  5   hold switches, bit i holds die i+1
//     cat_sel      in  4   selected category, 0..11
//     roll_en      out 1   high for the whole roll burst
//     hold_out     out 5   hold mask for the dice manager
//     roll_count   out 2   rolls completed this turn, 0..3
//     round_num    out 4   current round, 0..11 (stays 11 after game over)
//     cat_used     out 12  bit k set once category k is committed
//     cat_commit   out 1   one-cycle pulse, cat_idx valid while high
//     cat_idx      out 4   category being committed
//     cat_err      out 1   one-cycle pulse after a rejected confirm
//     game_over    out 1   level, high after the final commit
// -----------------------------------------------------------------------------
module yacht_turn_ctrl
  import yacht_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ROLL_CYCLES     = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               roll_btn,
  input  logic               confirm_btn,
  input  logic [4:0]         hold_sw,
  input  logic [CAT_W-1:0]   cat_sel,
  output logic               roll_en,
  output logic [4:0]         hold_out,
  output logic [ROLLS_W-1:0] roll_count,
  output logic [ROUND_W-1:0] round_num,
  output logic [NUM_CAT-1:0] cat_used,
  output logic               cat_commit,
  output logic [CAT_W-1:0]   cat_idx,
  output logic               cat_err,
  output logic               game_over
);

  localparam int BURST_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(ROLL_CYCLES - 1);
  localparam logic [ROLLS_W-1:0] ROLLS_MAX  = ROLLS_W'(MAX_ROLLS);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_CAT - 1);
  localparam logic [NUM_CAT-1:0] CAT_ONE    = {{(NUM_CAT-1){1'b0}}, 1'b1};

  logic roll_p;
  logic confirm_p;

  turn_state_e        state_q,      state_d;
  logic [BURST_W-1:0] burst_q,      burst_d;
  logic [ROLLS_W-1:0] roll_count_q, roll_count_d;
  logic [ROUND_W-1:0] round_q,      round_d;
  logic [NUM_CAT-1:0] cat_used_q,   cat_used_d;
  logic [CAT_W-1:0]   cat_idx_q,    cat_idx_d;
  logic               cat_err_q,    cat_err_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_roll_db (
    .clk_i   (clk),
    .reset_i (reset),
    .btn_i   (roll_btn),
    .press_o (roll_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clk_i   (clk),
    .reset_i (reset),
    .btn_i   (confirm_btn),
    .press_o (confirm_p)
  );

  // Next-state logic. Press pulses last a single cycle, so any press that
  // arrives in a state that does not act on it is simply dropped.
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    roll_count_d = roll_count_q;
    round_d      = round_q;
    cat_used_d   = cat_used_q;
    cat_idx_d    = cat_idx_q;
    cat_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (roll_p) begin
          burst_d = BURST_LAST;
          state_d = ROLLING;
        end
      end

      ROLLING: begin
        if (burst_q == '0) begin
          roll_count_d = roll_count_q + 1'b1;
          state_d      = DECIDE;
        end else begin
          burst_d = burst_q - 1'b1;
        end
      end

      DECIDE: begin
        // Confirm has priority over a simultaneous roll press.
        if (confirm_p) begin
          if (cat_is_free(cat_sel, cat_used_q)) begin
            cat_idx_d = cat_sel;
            state_d   = COMMIT;
          end else begin
            cat_err_d = 1'b1;
          end
        end else if (roll_p && (roll_count_q < ROLLS_MAX)) begin
          burst_d = BURST_LAST;
          state_d = ROLLING;
        end
      end

      COMMIT: begin
        cat_used_d   = cat_used_q | (CAT_ONE << cat_idx_q);
        roll_count_d = '0;
        if (round_q == ROUND_LAST) begin
          state_d = GAME_OVER;
        end else begin
          round_d = round_q + 1'b1;
          state_d = IDLE;
        end
      end

      GAME_OVER: begin
        state_d = GAME_OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      roll_count_q <= '0;
      round_q      <= '0;
      cat_used_q   <= '0;
      cat_idx_q    <= '0;
      cat_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      roll_count_q <= roll_count_d;
      round_q      <= round_d;
      cat_used_q   <= cat_used_d;
      cat_idx_q    <= cat_idx_d;
      cat_err_q    <= cat_err_d;
    end
  end

  // The burst counter is reloaded on every entry to ROLLING, so it needs no
  // reset of its own.
  always_ff @(posedge clk) begin
    burst_q <= burst_d;
  end

  // On the first roll of a turn every die must roll, so holds are masked off.
  assign hold_out   = (roll_count_q == '0) ? 5'b00000 : hold_sw;
  assign roll_en    = (state_q == ROLLING);
  assign cat_commit = (state_q == COMMIT);
  assign game_over  = (state_q == GAME_OVER);
  assign roll_count = roll_count_q;
  assign round_num  = round_q;
  assign cat_used   = cat_used_q;
  assign cat_idx    = cat_idx_q;
  assign cat_err    = cat_err_q;

endmodule

// File: tb/tb_yacht_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_yacht_turn_ctrl
//   Directed bench for yacht_turn_ctrl with DEBOUNCE_CYCLES=4, ROLL_CYCLES=8.
//   A game-level reference model runs alongside the DUT and is compared every
//   cycle; hand-computed literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_yacht_turn_ctrl;

  localparam int DEB  = 4;
  localparam int RC   = 8;
  localparam int NCAT = 12;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        roll_btn = 1'b0;
  logic        confirm_btn = 1'b0;
  logic [4:0]  hold_sw = 5'b10101;
  logic [3:0]  cat_sel = 4'd0;
  logic        roll_en;
  logic [4:0]  hold_out;
  logic [1:0]  roll_count;
  logic [3:0]  round_num;
  logic [11:0] cat_used;
  logic        cat_commit;
  logic [3:0]  cat_idx;
  logic        cat_err;
  logic        game_over;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  yacht_turn_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .ROLL_CYCLES     (RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .roll_btn    (roll_btn),
    .confirm_btn (confirm_btn),
    .hold_sw     (hold_sw),
    .cat_sel     (cat_sel),
    .roll_en     (roll_en),
    .hold_out    (hold_out),
    .roll_count  (roll_count),
    .round_num   (round_num),
    .cat_used    (cat_used),
    .cat_commit  (cat_commit),
    .cat_idx     (cat_idx),
    .cat_err     (cat_err),
    .game_over   (game_over)
  );

  // ---------------------------------------------------------------------------
  // Reference model: game rules in terms of "burst cycles left", "rolls this
  // turn", "rounds played", etc. A button press is accepted once the button
  // has been seen at a steady level for DEB samples, those samples lagging
  // the pin by the two synchronizer stages.
  // ---------------------------------------------------------------------------
  int          m_burst_left;
  int          m_rolls;
  int          m_round;
  int          m_idx;
  logic [11:0] m_used;
  logic        m_commit, m_err, m_over;
  logic [DEB:0] h_roll, h_conf;   // bit 0 = most recent pin sample
  logic        lv_roll, lv_conf, p_roll, p_conf;
  bit          m_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_burst_left = 0; m_rolls = 0; m_round = 0; m_idx = 0; m_used = '0;
      m_commit = 0; m_err = 0; m_over = 0;
      h_roll = '0; h_conf = '0; lv_roll = 0; lv_conf = 0; p_roll = 0; p_conf = 0;
      m_live = 1;
    end else begin
      m_err = 0;
      if (m_over) begin
        // game finished: nothing moves until reset
      end else if (m_commit) begin
        m_used[m_idx] = 1'b1;
        m_rolls  = 0;
        m_commit = 0;
        if (m_round == NCAT - 1) m_over = 1;
        else m_round = m_round + 1;
      end else if (m_burst_left > 0) begin
        m_burst_left = m_burst_left - 1;
        if (m_burst_left == 0) m_rolls = m_rolls + 1;
      end else if (m_rolls == 0) begin
        if (p_roll) m_burst_left = RC;
      end else if (p_conf) begin
        if (cat_sel < NCAT && !m_used[cat_sel]) begin
          m_commit = 1;
          m_idx    = cat_sel;
        end else begin
          m_err = 1;
        end
      end else if (p_roll && m_rolls < MAXR) begin
        m_burst_left = RC;
      end

      // Press detection for the next cycle, from the lagged sample window.
      p_roll = !lv_roll && (&h_roll[DEB:1]);
      if (p_roll) lv_roll = 1;
      else if (lv_roll && !(|h_roll[DEB:1])) lv_roll = 0;
      h_roll = {h_roll[DEB-1:0], roll_btn};

      p_conf = !lv_conf && (&h_conf[DEB:1]);
      if (p_conf) lv_conf = 1;
      else if (lv_conf && !(|h_conf[DEB:1])) lv_conf = 0;
      h_conf = {h_conf[DEB-1:0], confirm_btn};
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [30:0] exp_v, got_v;
  always @(negedge clk) begin
    if (m_live) begin
      exp_v = {m_burst_left > 0, (m_rolls == 0) ? 5'b00000 : hold_sw, 2'(m_rolls),
               4'(m_round), m_used, m_commit, 4'(m_idx), m_err, m_over};
      got_v = {roll_en, hold_out, roll_count, round_num, cat_used, cat_commit,
               cat_idx, cat_err, game_over};
      n_chk = n_chk + 1;
      if (got_v !== exp_v) begin
        n_fail = n_fail + 1;
        $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, got_v, exp_v);
      end
    end
  end

  // Event counters used by the literal checks.
  int en_cycles = 0, hold0_cycles = 0, holdsw_cycles = 0;
  int commits = 0, errs = 0, last_idx = -1;
  always @(negedge clk) begin
    if (!reset) begin
      if (roll_en === 1'b1) begin
        en_cycles = en_cycles + 1;
        if (hold_out === 5'b00000) hold0_cycles = hold0_cycles + 1;
        if (hold_out === 5'b10101) holdsw_cycles = holdsw_cycles + 1;
      end
      if (cat_commit === 1'b1) begin
        commits  = commits + 1;
        last_idx = cat_idx;
      end
      if (cat_err === 1'b1) errs = errs + 1;
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    n_chk = n_chk + 1;
    if (got != expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press_roll(input int hold);
    roll_btn = 1'b1;
    tick(hold);
    roll_btn = 1'b0;
    tick(10);
  endtask

  task automatic press_conf(input int hold);
    confirm_btn = 1'b1;
    tick(hold);
    confirm_btn = 1'b0;
    tick(10);
  endtask

  task automatic press_both(input int hold);
    roll_btn    = 1'b1;
    confirm_btn = 1'b1;
    tick(hold);
    roll_btn    = 1'b0;
    confirm_btn = 1'b0;
    tick(10);
  endtask

  int lat;
  int en_snap;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);

    // Reset state
    chk("rst_roll_en",    roll_en,    0);
    chk("rst_roll_count", roll_count, 0);
    chk("rst_round",      round_num,  0);
    chk("rst_cat_used",   cat_used,   0);
    chk("rst_game_over",  game_over,  0);

    // 3-cycle glitch: shorter than the debounce window
    roll_btn = 1'b1;
    tick(3);
    roll_btn = 1'b0;
    tick(20);
    chk("glitch_no_burst", en_cycles,  0);
    chk("glitch_count",    roll_count, 0);

    // Clean press held 20 cycles: sync(2) + debounce(4) + FSM edge(1)
    roll_btn = 1'b1;
    lat = 0;
    while (roll_en !== 1'b1 && lat < 50) begin
      tick(1);
      lat = lat + 1;
    end
    chk("press_latency", lat, 7);
    tick(20 - lat);
    roll_btn = 1'b0;
    tick(10);
    chk("burst1_len",       en_cycles,    8);
    chk("burst1_hold_zero", hold0_cycles, 8);
    chk("burst1_count",     roll_count,   1);

    // Commit category 5 after one roll
    cat_sel = 4'd5;
    press_conf(8);
    chk("commit5_n",    commits,   1);
    chk("commit5_idx",  last_idx,  5);
    chk("commit5_used", cat_used,  12'h020);
    chk("commit5_round", round_num, 1);
    chk("commit5_rolls", roll_count, 0);

    // Next turn: reject used and out-of-range categories
    press_roll(20);
    cat_sel = 4'd5;
    press_conf(8);
    chk("err_used_n",      errs,    1);
    chk("err_used_commit", commits, 1);
    cat_sel = 4'd13;
    press_conf(8);
    chk("err_range_n",      errs,    2);
    chk("err_range_commit", commits, 1);

    // Two more rolls show the hold mask; a fourth press does nothing
    press_roll(20);
    press_roll(20);
    chk("hold_bursts",  holdsw_cycles, 16);
    chk("three_rolls",  roll_count,    3);
    en_snap = en_cycles;
    press_roll(20);
    chk("fourth_no_burst", en_cycles,  en_snap);
    chk("fourth_count",    roll_count, 3);

    // Simultaneous roll+confirm: confirm wins
    cat_sel = 4'd0;
    press_both(8);
    chk("both_commit_n",  commits,   2);
    chk("both_idx",       last_idx,  0);
    chk("both_no_burst",  en_cycles, en_snap);
    chk("both_used",      cat_used,  12'h021);

    // Remaining ten turns
    for (int c = 1; c < NCAT; c++) begin
      if (c != 5) begin
        press_roll(20);
        cat_sel = 4'(c);
        press_conf(8);
      end
    end
    chk("go_commits",  commits,   12);
    chk("go_flag",     game_over, 1);
    chk("go_used",     cat_used,  12'hFFF);
    chk("go_round",    round_num, 11);

    // Presses after game over are ignored
    en_snap = en_cycles;
    press_roll(20);
    cat_sel = 4'd3;
    press_conf(8);
    chk("go_no_burst",  en_cycles, en_snap);
    chk("go_no_commit", commits,   12);
    chk("go_stays",     game_over, 1);

    // New game, reset in the middle of a burst
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    roll_btn = 1'b1;
    lat = 0;
    while (roll_en !== 1'b1 && lat < 50) begin
      tick(1);
      lat = lat + 1;
    end
    chk("rerun_latency", lat, 7);
    tick(3);
    reset    = 1'b1;
    roll_btn = 1'b0;
    tick(1);
    chk("midrst_roll_en",   roll_en,    0);
    chk("midrst_count",     roll_count, 0);
    chk("midrst_round",     round_num,  0);
    chk("midrst_used",      cat_used,   0);
    chk("midrst_game_over", game_over,  0);
    chk("midrst_cat_idx",   cat_idx,    0);
    reset = 1'b0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/yacht_turn_ctrl.md
Name: yacht_turn_ctrl

Overview:
- Turn/round controller directly upstream of the dice manager.
- Debounces the Roll and Confirm push-buttons and generates the multi-cycle roll_en burst the dice manager consumes.
- Enforces the 3-rolls-per-turn rule and forces all dice to roll on a turn's first roll.
- Validates and commits the player's scoring category, and tracks the 12 rounds through to game over.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable samples required before a button level is accepted (≥2)
ROLL_CYCLES, 25000000, length of each roll_en burst in clk cycles (≥1)
MAX_ROLLS, 3, rolls allowed per turn
NUM_CAT, 12, scoring categories / rounds per game

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
roll_btn  in  1  raw Roll button, asynchronous, active-high
confirm_btn  in  1  raw Confirm button, asynchronous, active-high
hold_sw  in  5  DIP hold switches (bit i holds die i+1)
cat_sel  in  4  selected category index, 0..11
roll_en  out  1  roll request to dice manager; high for the entire burst
hold_out  out  5  hold mask to dice manager
roll_count  out  2  rolls completed this turn, 0..3
round_num  out  4  current round, 0..11; holds at 11 after game over
cat_used  out  12  bit k set once category k is committed
cat_commit  out  1  one-cycle pulse; commits cat_idx
cat_idx  out  4  category being committed; valid while cat_commit=1
cat_err  out  1  one-cycle pulse on rejected confirm
game_over  out  1  level; high after the 12th commit

Behaviour:
- Reset (reset=1 at a clk edge) clears all outputs to 0 and sets the FSM to IDLE. Debouncer state clears to "released".
- Reset overrides everything. Reset mid-burst drops roll_en on the next edge.
- Buttons: 2-FF synchronizer, then debounce counter. The debounced level toggles once the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. A rising edge of the debounced level gives a one-cycle press pulse (roll_p, confirm_p).
- Latency: button edge to press pulse is 2 + DEBOUNCE_CYCLES cycles. Holding a button produces exactly one pulse.
- hold_out = 5'b00000 when roll_count==0, else hold_sw. Evaluated combinationally from registered roll_count.
- FSM states and transitions:
  - IDLE: roll_p → ROLLING, burst counter = ROLL_CYCLES-1. confirm_p is ignored, with no cat_err.
  - ROLLING: roll_en=1. Counter decrements each cycle. At 0 → roll_count+1, go to DECIDE. roll_en is high for exactly ROLL_CYCLES cycles. All presses are ignored and discarded.
  - DECIDE, on confirm_p:
    - If cat_sel<NUM_CAT and cat_used[cat_sel]==0 → COMMIT.
    - Otherwise cat_err pulses and the FSM stays in DECIDE.
  - DECIDE, on roll_p:
    - If roll_count<MAX_ROLLS → ROLLING.
    - If roll_count==MAX_ROLLS → ignored, no error.
  - DECIDE, simultaneous confirm_p and roll_p: confirm wins and roll_p is discarded.
  - COMMIT (one cycle): cat_commit=1, cat_idx=latched cat_sel, set cat_used bit, roll_count→0.
    - If round_num==NUM_CAT-1 → GAME_OVER.
    - Else round_num+1 → IDLE.
  - GAME_OVER: game_over=1, all presses ignored; exit only via reset.
- cat_sel is latched when confirm_p is accepted. Later changes to cat_sel do not affect cat_idx.
- hold_sw changes during ROLLING pass straight through; the dice manager samples them each cycle.
- Width rules:
  - Burst counter is clog2(ROLL_CYCLES) bits, min 1.
  - Debounce counter is clog2(DEBOUNCE_CYCLES) bits.
  - roll_count never exceeds MAX_ROLLS.
  - round_num never wraps.

Decomposition:
- Shared package yacht_pkg holds:
  - NUM_CAT and MAX_ROLLS
  - category index constants CAT_ACES..CAT_SIXES, CAT_CHOICE, CAT_4KIND, CAT_FULLH, CAT_SSTR, CAT_LSTR, CAT_YACHT (0..11)
  - FSM state encoding (IDLE, ROLLING, DECIDE, COMMIT, GAME_OVER)
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge pulse. It is instantiated twice.

Test Plan:
All scenarios use bench parameters DEBOUNCE_CYCLES=4, ROLL_CYCLES=8.
- Reset, then a clean roll_btn press held 20 cycles → exactly one burst: roll_en high for 8 consecutive cycles, hold_out=00000 throughout, then roll_count=1.
- hold_sw=10101, then three rolls, then a fourth roll press → bursts 2 and 3 show hold_out=10101. The fourth press produces no roll_en; roll_count stays 3.
- roll_btn glitch high for 3 cycles, then low → no press pulse, no roll_en; FSM stays IDLE.
- After one roll, cat_sel=5 plus confirm → cat_commit one cycle with cat_idx=5, cat_used=000000100000, round_num=1, roll_count=0.
- Repeat cat_sel=5 confirm next turn → cat_err pulse, no commit. Then cat_sel=13 confirm → cat_err. Then roll and confirm pressed in the same cycle in DECIDE with cat_sel=0 → commit of category 0, no burst.
- Twelve full turns over categories 0..11 → game_over=1 after the 12th commit, cat_used=FFF, round_num=11. Further presses have no effect. reset=1 mid-burst on a later run → roll_en=0 on the next edge, all outputs 0.
